// File: rtl/prog_mem_loader.sv
// prog_mem_loader: assembles a serial byte stream (MSB first) into INSTR_WIDTH-bit
// instruction words and writes them to program memory from address 0, holding the CPU
// for the duration of the load.
// Optional feature: define OPCODE_CHECK_EN to reject words whose opcode is not in the
// legal set; an illegal word aborts the load and raises the sticky err flag.

`ifndef NOP
`define NOP  6'd0
`define ADD  6'd1
`define SUB  6'd2
`define ADDI 6'd3
`define SUBI 6'd4
`define BEQ  6'd5
`define BNE  6'd6
`define BGE  6'd7
`endif

module prog_mem_loader #(
    parameter int unsigned INSTR_WIDTH  = 24,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned OPCODE_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  len,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   pm_we,
    output logic [ADDR_WIDTH-1:0]  pm_addr,
    output logic [INSTR_WIDTH-1:0] pm_wdata,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned BPW = (INSTR_WIDTH + 7) / 8;
    localparam int unsigned SW  = 8 * BPW;
    localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;

`ifdef OPCODE_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                  state, state_nx;
    logic [SW-1:0]           shreg;
    logic [BCW-1:0]          bcnt;
    logic [ADDR_WIDTH-1:0]   words_left;
    logic                    err_q;
    logic                    last_byte;
    logic                    opc_legal;
    logic                    word_ok;
    logic [OPCODE_WIDTH-1:0] opcode;

    assign last_byte = (bcnt == BCW'(BPW - 1));
    assign opcode    = shreg[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign word_ok   = !CHECK || opc_legal;
    assign pm_wdata  = shreg[INSTR_WIDTH-1:0];
    assign err       = CHECK ? err_q : 1'b0;

    // Opcode legality against the picoMIPS instruction set
    always_comb begin
        opc_legal = 1'b0;
        case (opcode)
            OPCODE_WIDTH'(`NOP), OPCODE_WIDTH'(`ADD), OPCODE_WIDTH'(`SUB),
            OPCODE_WIDTH'(`ADDI), OPCODE_WIDTH'(`SUBI), OPCODE_WIDTH'(`BEQ),
            OPCODE_WIDTH'(`BNE), OPCODE_WIDTH'(`BGE): opc_legal = 1'b1;
            default: opc_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state and Moore outputs
    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        pm_we      = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nx = (len == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid && last_byte) state_nx = WRITE;
            end
            WRITE: begin
                cpu_hold = 1'b1;
                pm_we    = word_ok;
                if (!word_ok || words_left == ADDR_WIDTH'(1)) state_nx = DONE;
                else                                          state_nx = COLLECT;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Word assembly, byte/word counters, write address and sticky error
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            shreg      <= '0;
            bcnt       <= '0;
            words_left <= '0;
            pm_addr    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        words_left <= len;
                        pm_addr    <= '0;
                        err_q      <= 1'b0;
                        bcnt       <= '0;
                    end
                end
                COLLECT: begin
                    if (byte_valid) begin
                        // Shift-left form stays legal for BPW==1; surplus high bits fall off the top.
                        shreg <= (shreg << 8) | SW'(byte_in);
                        bcnt  <= last_byte ? '0 : bcnt + BCW'(1);
                    end
                end
                WRITE: begin
                    if (word_ok) begin
                        pm_addr    <= pm_addr + ADDR_WIDTH'(1);
                        words_left <= words_left - ADDR_WIDTH'(1);
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: directed steps with randomized word data,
// compared against a queue-based reference of the expected program memory writes.

`ifndef NOP
`define NOP  6'd0
`define ADD  6'd1
`define SUB  6'd2
`define ADDI 6'd3
`define SUBI 6'd4
`define BEQ  6'd5
`define BNE  6'd6
`define BGE  6'd7
`endif

module tb_prog_mem_loader;

    localparam int IW  = 24;
    localparam int AW  = 8;
    localparam int OW  = 6;
    localparam int BPW = (IW + 7) / 8;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] len = '0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready, pm_we, cpu_hold, busy, done, err;
    logic [AW-1:0] pm_addr;
    logic [IW-1:0] pm_wdata;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned fails  = 0;
    bit          vphase = 1'b1;
    logic [OW-1:0] legal_ops [8];

    prog_mem_loader #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .OPCODE_WIDTH(OW)) dut (
        .clk(clk), .nReset(nReset), .start(start), .len(len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Observation log, sampled on the falling edge
    logic [AW-1:0] wr_addr [$];
    logic [IW-1:0] wr_data [$];
    time           wr_t    [$];
    bit            wr_hold [$];
    time           done_t  [$];
    bit            done_hold [$];
    bit            done_err  [$];
    time           rdy_t   [$];
    int unsigned   hold_cnt = 0;

    always @(negedge clk) begin
        if (pm_we) begin
            wr_addr.push_back(pm_addr);
            wr_data.push_back(pm_wdata);
            wr_t.push_back($time);
            wr_hold.push_back(cpu_hold);
        end
        if (done) begin
            done_t.push_back($time);
            done_hold.push_back(cpu_hold);
            done_err.push_back(err);
        end
        if (byte_ready) rdy_t.push_back($time);
        if (cpu_hold) hold_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] outs();
        return {byte_ready, pm_we, pm_addr, pm_wdata, cpu_hold, busy, done, err};
    endfunction

    function automatic logic [IW-1:0] rnd_word();
        return {legal_ops[$urandom_range(0, 7)], (IW-OW)'($urandom)};
    endfunction

    // Called at a falling edge; start is seen by the next rising edge
    task automatic do_start(input logic [AW-1:0] l, output time tn);
        start = 1'b1;
        len   = l;
        tn    = $time;
        @(negedge clk);
        start = 1'b0;
        len   = AW'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle, output time t_acc);
        bit got = 1'b0;
        int unsigned n = 0;
        byte_in = b;
        t_acc = 0;
        while (!got && n < 64) begin
            if (toggle) begin
                byte_valid = vphase;
                vphase = !vphase;
            end else begin
                byte_valid = 1'b1;
            end
            if (byte_valid && byte_ready) begin
                got = 1'b1;
                t_acc = $time;
            end
            @(negedge clk);
            n++;
        end
        byte_valid = 1'b0;
        chk("byte_accept", got, 1'b1);
    endtask

    task automatic send_word(input logic [IW-1:0] w, input bit toggle, output time t_acc);
        logic [8*BPW-1:0] wb = (8*BPW)'(w);
        for (int k = 0; k < BPW; k++)
            send_byte(wb[8*(BPW-1-k) +: 8], toggle, t_acc);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic load(input logic [AW-1:0] l, input logic [IW-1:0] words [$],
                        input bit toggle, output time last_acc);
        time tn;
        do_start(l, tn);
        foreach (words[i]) send_word(words[i], toggle, last_acc);
        wait_idle();
    endtask

    // Reference: a load of N words writes word i at address i, in order
    task automatic check_writes(input string tag, input int base, input logic [IW-1:0] words [$]);
        chk({tag, "_count"}, wr_data.size() - base, words.size());
        foreach (words[i]) begin
            if (base + i < wr_data.size()) begin
                chk({tag, "_addr"}, wr_addr[base+i], AW'(i));
                chk({tag, "_data"}, wr_data[base+i], words[i]);
            end
        end
    endtask

    initial begin
        logic [IW-1:0] words [$];
        time tn, tacc;
        int  wb, db, rb, nrdy;
        int unsigned hb;
        logic [AW-1:0] l;

        legal_ops = '{`NOP, `ADD, `SUB, `ADDI, `SUBI, `BEQ, `BNE, `BGE};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outs", outs(), '0);
        nReset = 1'b1;
        @(negedge clk);
        chk("idle_outs", outs(), '0);

        // Asynchronous reset in the middle of a word, then a clean load
        do_start(1, tn);
        send_byte(8'hA5, 1'b0, tacc);
        send_byte(8'h5A, 1'b0, tacc);
        chk("mid_collect_busy", busy, 1'b1);
        nReset = 1'b0;
        #1;
        chk("async_reset_outs", outs(), '0);
        @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        wb = wr_data.size();
        words = '{rnd_word()};
        load(1, words, 1'b0, tacc);
        check_writes("post_reset", wb, words);

        // Two-word load with byte_valid held high: timing of writes and done
        wb = wr_data.size(); db = done_t.size(); rb = rdy_t.size();
        words = '{{`ADDI, 18'h00105}, {`BNE, 18'h3FFFE}};
        load(2, words, 1'b0, tacc);
        check_writes("two_word", wb, words);
        if (wr_data.size() >= wb + 2 && done_t.size() > db) begin
            chk("write_spacing", wr_t[wb+1] - wr_t[wb], 40);
            nrdy = 0;
            for (int i = rb; i < rdy_t.size(); i++)
                if (rdy_t[i] > wr_t[wb] && rdy_t[i] < wr_t[wb+1]) nrdy++;
            chk("ready_between_writes", nrdy, 3);
            chk("hold_during_write", wr_hold[wb], 1'b1);
            chk("done_after_write", done_t[db], wr_t[wb+1] + 10);
            chk("done_hold_low", done_hold[db], 1'b0);
        end else begin
            chk("two_word_events", 1'b0, 1'b1);
        end

        // byte_valid toggling every cycle
        wb = wr_data.size();
        words = '{rnd_word()};
        load(1, words, 1'b1, tacc);
        check_writes("toggle", wb, words);
        if (wr_data.size() > wb) chk("toggle_latency", wr_t[wb], tacc + 10);

        // len == 0: immediate done, nothing written, CPU never held
        wb = wr_data.size(); db = done_t.size(); rb = rdy_t.size(); hb = hold_cnt;
        do_start(0, tn);
        repeat (3) @(negedge clk);
        chk("len0_no_write", wr_data.size(), wb);
        chk("len0_done_count", done_t.size(), db + 1);
        if (done_t.size() > db) chk("len0_done_time", done_t[db], tn + 10);
        chk("len0_no_hold", hold_cnt, hb);
        chk("len0_no_ready", rdy_t.size(), rb);

        // start re-pulsed while busy is ignored
        wb = wr_data.size(); db = done_t.size();
        words = '{rnd_word()};
        do_start(1, tn);
        send_byte(words[0][23:16], 1'b0, tacc);
        start = 1'b1;
        len   = 5;
        send_byte(words[0][15:8], 1'b0, tacc);
        start = 1'b0;
        send_byte(words[0][7:0], 1'b0, tacc);
        wait_idle();
        repeat (4) @(negedge clk);
        check_writes("restart_ignored", wb, words);
        chk("restart_done_count", done_t.size(), db + 1);
        chk("restart_addr_hold", pm_addr, 1);

        // Randomized loads
        for (int r = 0; r < 4; r++) begin
            l = AW'($urandom_range(1, 6));
            words = {};
            for (int i = 0; i < l; i++) words.push_back(rnd_word());
            wb = wr_data.size(); db = done_t.size();
            load(l, words, bit'($urandom_range(0, 1)), tacc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_writes("random_load", wb, words);
            chk("random_done", done_t.size(), db + 1);
            chk("random_final_addr", pm_addr, l);
            chk("random_no_hold_idle", cpu_hold, 1'b0);
        end

`ifdef OPCODE_CHECK_EN
        // Illegal opcode in the second word aborts the load
        wb = wr_data.size(); db = done_t.size();
        words = '{rnd_word()};
        do_start(3, tn);
        send_word(words[0], 1'b0, tacc);
        send_word({6'h3F, 18'h12345}, 1'b0, tacc);
        wait_idle();
        check_writes("abort", wb, words);
        chk("abort_done_count", done_t.size(), db + 1);
        if (done_t.size() > db) begin
            chk("abort_done_time", done_t[db], tacc + 20);
            chk("abort_err_at_done", done_err[db], 1'b1);
            chk("abort_hold_low", done_hold[db], 1'b0);
        end
        chk("abort_addr", pm_addr, 1);
        chk("err_sticky", err, 1'b1);
        do_start(0, tn);
        chk("err_cleared", err, 1'b0);
        wait_idle();
`else
        chk("err_tied_low", err, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
